// File: rtl/eth_axis_rx_arbiter.sv
// eth_axis_rx_arbiter
// Packet-atomic round-robin merge of several MAC RX AXI-Stream lanes into a
// single stream for the DMA engine. Each forwarded beat carries its source
// lane on m_tdest, and a wrapping packet counter is kept for every lane.

module eth_axis_rx_arbiter #(
    parameter int NUM_CHANNELS = 2,
    parameter int DATA_BITS    = 64,
    parameter int DEST_BITS    = 4,
    parameter int CNT_BITS     = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  s_tdata,
    input  logic [NUM_CHANNELS*DATA_BITS/8-1:0] s_tkeep,
    input  logic [NUM_CHANNELS-1:0]            s_tlast,
    input  logic [NUM_CHANNELS-1:0]            s_tuser,
    input  logic [NUM_CHANNELS-1:0]            s_tvalid,
    output logic [NUM_CHANNELS-1:0]            s_tready,
    output logic [DATA_BITS-1:0]               m_tdata,
    output logic [DATA_BITS/8-1:0]             m_tkeep,
    output logic                               m_tlast,
    output logic                               m_tuser,
    output logic [DEST_BITS-1:0]               m_tdest,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [NUM_CHANNELS*CNT_BITS-1:0]   pkt_count
);

    localparam int KEEP_BITS  = DATA_BITS / 8;
    localparam int GRANT_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [GRANT_BITS-1:0] LAST_CHANNEL = GRANT_BITS'(NUM_CHANNELS - 1);

    typedef enum logic {
        IDLE,
        PASS
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [GRANT_BITS-1:0] grant;
    logic [GRANT_BITS-1:0] last_grant;
    logic [GRANT_BITS-1:0] rr_pick;
    logic [GRANT_BITS-1:0] rr_cand;
    logic                  rr_found;

    logic [DATA_BITS-1:0]  sel_data;
    logic [KEEP_BITS-1:0]  sel_keep;
    logic                  sel_last;
    logic                  sel_user;
    logic                  sel_valid;

    logic                  slot_free;
    logic                  accept;
    logic                  pkt_end;

    // The output slot can take a new beat when it is empty or being drained this cycle.
    assign slot_free = !m_tvalid || m_tready;
    assign accept    = (state == PASS) && sel_valid && slot_free;
    assign pkt_end   = accept && sel_last;

    // Round-robin search starting just after the last lane that finished a packet.
    always_comb begin
        rr_pick  = '0;
        rr_found = 1'b0;
        rr_cand  = last_grant;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            rr_cand = (rr_cand == LAST_CHANNEL) ? '0 : rr_cand + GRANT_BITS'(1);
            if (!rr_found && s_tvalid[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    // Steer the granted lane's sideband onto a single set of selected signals.
    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        sel_valid = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (grant == GRANT_BITS'(c)) begin
                sel_data  = s_tdata[c*DATA_BITS +: DATA_BITS];
                sel_keep  = s_tkeep[c*KEEP_BITS +: KEEP_BITS];
                sel_last  = s_tlast[c];
                sel_user  = s_tuser[c];
                sel_valid = s_tvalid[c];
            end
        end
    end

    // State register plus the grant bookkeeping that moves with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_CHANNEL;
        end else begin
            state <= state_next;
            if (state == IDLE && rr_found) begin
                grant <= rr_pick;
            end
            if (pkt_end) begin
                last_grant <= grant;
            end
        end
    end

    // Next state: arbitrate in IDLE, hold the grant in PASS until the packet's tlast is taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    state_next = PASS;
                end
            end
            PASS: begin
                if (pkt_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Only the granted lane sees ready, and only while passing a packet.
    always_comb begin
        s_tready = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            s_tready[c] = (state == PASS) && (grant == GRANT_BITS'(c)) && slot_free;
        end
    end

    // Output register slice: load on an accepted beat, drop valid once drained.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
            m_tdest  <= '0;
            m_tvalid <= 1'b0;
        end else if (accept) begin
            m_tdata  <= sel_data;
            m_tkeep  <= sel_keep;
            m_tlast  <= sel_last;
            m_tuser  <= sel_user;
            m_tdest  <= DEST_BITS'(grant);
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    // Per-lane packet counters, bumped when a lane's tlast beat is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (pkt_end) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (grant == GRANT_BITS'(c)) begin
                    pkt_count[c*CNT_BITS +: CNT_BITS] <= pkt_count[c*CNT_BITS +: CNT_BITS] + CNT_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_axis_rx_arbiter.sv
// Directed bench for eth_axis_rx_arbiter: a two-lane instance driven from a
// cycle table, and a four-lane instance with a narrow counter for lane
// selection and counter wrap.

module tb_eth_axis_rx_arbiter;

    logic clock;
    logic reset;

    // Two-lane instance, default widths.
    logic [127:0] s_tdata;
    logic [15:0]  s_tkeep;
    logic [1:0]   s_tlast;
    logic [1:0]   s_tuser;
    logic [1:0]   s_tvalid;
    logic [1:0]   s_tready;
    logic [63:0]  m_tdata;
    logic [7:0]   m_tkeep;
    logic         m_tlast;
    logic         m_tuser;
    logic [3:0]   m_tdest;
    logic         m_tvalid;
    logic         m_tready;
    logic [31:0]  pkt_count;

    // Four-lane instance, 32-bit data, 4-bit counters.
    logic [127:0] s4_tdata;
    logic [15:0]  s4_tkeep;
    logic [3:0]   s4_tlast;
    logic [3:0]   s4_tuser;
    logic [3:0]   s4_tvalid;
    logic [3:0]   s4_tready;
    logic [31:0]  m4_tdata;
    logic [3:0]   m4_tkeep;
    logic         m4_tlast;
    logic         m4_tuser;
    logic [2:0]   m4_tdest;
    logic         m4_tvalid;
    logic         m4_tready;
    logic [15:0]  pkt4_count;

    int total;
    int bad;

    typedef struct packed {
        logic [1:0] valid;
        logic [1:0] last;
        logic [1:0] user;
        logic       mready;
        logic [7:0] t0;
        logic [7:0] t1;
        logic [1:0] ready;
        logic       mv;
        logic       ml;
        logic       mu;
        logic [3:0] md;
        logic [7:0] mtag;
    } vec_t;

    localparam int NUM_VECS = 25;
    vec_t vecs [NUM_VECS];

    eth_axis_rx_arbiter #(
        .NUM_CHANNELS(2),
        .DATA_BITS(64),
        .DEST_BITS(4),
        .CNT_BITS(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .s_tdata(s_tdata),
        .s_tkeep(s_tkeep),
        .s_tlast(s_tlast),
        .s_tuser(s_tuser),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .m_tdata(m_tdata),
        .m_tkeep(m_tkeep),
        .m_tlast(m_tlast),
        .m_tuser(m_tuser),
        .m_tdest(m_tdest),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .pkt_count(pkt_count)
    );

    eth_axis_rx_arbiter #(
        .NUM_CHANNELS(4),
        .DATA_BITS(32),
        .DEST_BITS(3),
        .CNT_BITS(4)
    ) dut4 (
        .clock(clock),
        .reset(reset),
        .s_tdata(s4_tdata),
        .s_tkeep(s4_tkeep),
        .s_tlast(s4_tlast),
        .s_tuser(s4_tuser),
        .s_tvalid(s4_tvalid),
        .s_tready(s4_tready),
        .m_tdata(m4_tdata),
        .m_tkeep(m4_tkeep),
        .m_tlast(m4_tlast),
        .m_tuser(m4_tuser),
        .m_tdest(m4_tdest),
        .m_tvalid(m4_tvalid),
        .m_tready(m4_tready),
        .pkt_count(pkt4_count)
    );

    // Free-running 100 MHz clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        s_tvalid = v.valid;
        s_tlast  = v.last;
        s_tuser  = v.user;
        m_tready = v.mready;
        s_tdata  = {{8{v.t1}}, {8{v.t0}}};
        s_tkeep  = {v.t1, v.t0};
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // One packet of a single beat on the four-lane instance; mask says who requests.
    task automatic send4(input logic [3:0] mask, input int exp_ch, input logic [7:0] tag);
        logic [3:0] exp_ready;
        exp_ready = 4'b0001 << exp_ch;
        s4_tvalid = mask;
        s4_tlast  = 4'hF;
        s4_tdata  = {4{{4{tag}}}};
        s4_tkeep  = 16'hFFFF;
        #1;
        checkOutput("n4_idle_ready", 64'(s4_tready), 64'h0);
        nextCycle();
        checkOutput("n4_grant_ready", 64'(s4_tready), 64'(exp_ready));
        nextCycle();
        s4_tvalid = 4'h0;
        #1;
        checkOutput("n4_mvalid", 64'(m4_tvalid), 64'h1);
        checkOutput("n4_mdest", 64'(m4_tdest), 64'(exp_ch));
        checkOutput("n4_mdata", 64'(m4_tdata), 64'({4{tag}}));
        checkOutput("n4_mlast", 64'(m4_tlast), 64'h1);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Cycle table for the two-lane instance: inputs held during a cycle, and the
        // outputs visible in that same cycle (m_* reflect the beat taken at the previous edge).
        //            valid  last   user   mrdy  t0     t1     ready  mv    ml    mu    md     mtag
        // ch0 and ch1 together after reset: ch0's 3-beat packet first.
        vecs[0]  = '{2'b11, 2'b00, 2'b00, 1'b1, 8'hA1, 8'hB1, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00};
        vecs[1]  = '{2'b11, 2'b00, 2'b00, 1'b1, 8'hA1, 8'hB1, 2'b01, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00};
        vecs[2]  = '{2'b11, 2'b00, 2'b00, 1'b1, 8'hA2, 8'hB1, 2'b01, 1'b1, 1'b0, 1'b0, 4'd0, 8'hA1};
        vecs[3]  = '{2'b11, 2'b01, 2'b00, 1'b1, 8'hA3, 8'hB1, 2'b01, 1'b1, 1'b0, 1'b0, 4'd0, 8'hA2};
        // Idle bubble, then ch1 wins even though ch0 still requests; its tlast carries tuser.
        vecs[4]  = '{2'b11, 2'b00, 2'b00, 1'b1, 8'hC1, 8'hB1, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0, 8'hA3};
        vecs[5]  = '{2'b11, 2'b00, 2'b00, 1'b1, 8'hC1, 8'hB1, 2'b10, 1'b0, 1'b1, 1'b0, 4'd0, 8'hA3};
        vecs[6]  = '{2'b11, 2'b10, 2'b10, 1'b1, 8'hC1, 8'hB2, 2'b10, 1'b1, 1'b0, 1'b0, 4'd1, 8'hB1};
        vecs[7]  = '{2'b01, 2'b00, 2'b00, 1'b1, 8'hC1, 8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 4'd1, 8'hB2};
        // ch0 packet with m_tready low for five cycles after its first beat.
        vecs[8]  = '{2'b01, 2'b00, 2'b00, 1'b1, 8'hC1, 8'h00, 2'b01, 1'b0, 1'b1, 1'b1, 4'd1, 8'hB2};
        vecs[9]  = '{2'b01, 2'b00, 2'b00, 1'b0, 8'hC2, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 8'hC1};
        vecs[10] = '{2'b01, 2'b00, 2'b00, 1'b0, 8'hC2, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 8'hC1};
        vecs[11] = '{2'b01, 2'b00, 2'b00, 1'b0, 8'hC2, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 8'hC1};
        vecs[12] = '{2'b01, 2'b00, 2'b00, 1'b0, 8'hC2, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 8'hC1};
        vecs[13] = '{2'b01, 2'b00, 2'b00, 1'b0, 8'hC2, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 8'hC1};
        vecs[14] = '{2'b01, 2'b00, 2'b00, 1'b1, 8'hC2, 8'h00, 2'b01, 1'b1, 1'b0, 1'b0, 4'd0, 8'hC1};
        vecs[15] = '{2'b01, 2'b01, 2'b00, 1'b1, 8'hC3, 8'h00, 2'b01, 1'b1, 1'b0, 1'b0, 4'd0, 8'hC2};
        vecs[16] = '{2'b00, 2'b00, 2'b00, 1'b1, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0, 8'hC3};
        vecs[17] = '{2'b00, 2'b00, 2'b00, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0, 8'hC3};
        // Both lanes offering 1-beat packets: ch0 went last, so the order is 1,0,1.
        vecs[18] = '{2'b11, 2'b11, 2'b00, 1'b1, 8'hD0, 8'hE0, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0, 8'hC3};
        vecs[19] = '{2'b11, 2'b11, 2'b00, 1'b1, 8'hD0, 8'hE0, 2'b10, 1'b0, 1'b1, 1'b0, 4'd0, 8'hC3};
        vecs[20] = '{2'b11, 2'b11, 2'b00, 1'b1, 8'hD1, 8'hE1, 2'b00, 1'b1, 1'b1, 1'b0, 4'd1, 8'hE0};
        vecs[21] = '{2'b11, 2'b11, 2'b00, 1'b1, 8'hD1, 8'hE1, 2'b01, 1'b0, 1'b1, 1'b0, 4'd1, 8'hE0};
        vecs[22] = '{2'b11, 2'b11, 2'b00, 1'b1, 8'hD2, 8'hE2, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0, 8'hD1};
        vecs[23] = '{2'b11, 2'b11, 2'b00, 1'b1, 8'hD2, 8'hE2, 2'b10, 1'b0, 1'b1, 1'b0, 4'd0, 8'hD1};
        vecs[24] = '{2'b00, 2'b00, 2'b00, 1'b1, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 4'd1, 8'hE2};

        s_tvalid  = '0;
        s_tlast   = '0;
        s_tuser   = '0;
        s_tdata   = '0;
        s_tkeep   = '0;
        m_tready  = 1'b1;
        s4_tvalid = '0;
        s4_tlast  = '0;
        s4_tuser  = '0;
        s4_tdata  = '0;
        s4_tkeep  = '0;
        m4_tready = 1'b1;

        // Reset state, checked while reset is still held with a request pending.
        reset = 1'b1;
        s_tvalid = 2'b11;
        nextCycle();
        nextCycle();
        checkOutput("rst_ready", 64'(s_tready), 64'h0);
        checkOutput("rst_mvalid", 64'(m_tvalid), 64'h0);
        checkOutput("rst_mdata", m_tdata, 64'h0);
        checkOutput("rst_mdest", 64'(m_tdest), 64'h0);
        checkOutput("rst_count", 64'(pkt_count), 64'h0);
        reset = 1'b0;
        s_tvalid = 2'b00;

        $display("[TB] running cycle table");
        for (int r = 0; r < NUM_VECS; r++) begin
            applyStimulus(vecs[r]);
            #1;
            checkOutput($sformatf("row%0d_ready", r), 64'(s_tready), 64'(vecs[r].ready));
            checkOutput($sformatf("row%0d_mvalid", r), 64'(m_tvalid), 64'(vecs[r].mv));
            checkOutput($sformatf("row%0d_mlast", r), 64'(m_tlast), 64'(vecs[r].ml));
            checkOutput($sformatf("row%0d_muser", r), 64'(m_tuser), 64'(vecs[r].mu));
            checkOutput($sformatf("row%0d_mdest", r), 64'(m_tdest), 64'(vecs[r].md));
            checkOutput($sformatf("row%0d_mdata", r), m_tdata, {8{vecs[r].mtag}});
            checkOutput($sformatf("row%0d_mkeep", r), 64'(m_tkeep), 64'(vecs[r].mtag));
            nextCycle();
        end
        checkOutput("count_ch0", 64'(pkt_count[15:0]), 64'd3);
        checkOutput("count_ch1", 64'(pkt_count[31:16]), 64'd3);

        // Reset arriving during beat 2 of a 4-beat ch0 packet.
        $display("[TB] reset mid-packet");
        s_tvalid = 2'b01;
        s_tlast  = 2'b00;
        s_tdata  = {64'h0, {8{8'h51}}};
        s_tkeep  = 16'h00FF;
        nextCycle();
        nextCycle();
        s_tdata  = {64'h0, {8{8'h52}}};
        #1;
        checkOutput("mid_beat1", m_tdata, {8{8'h51}});
        checkOutput("mid_ready", 64'(s_tready), 64'h1);
        reset = 1'b1;
        #1;
        checkOutput("async_mvalid", 64'(m_tvalid), 64'h0);
        checkOutput("async_mdata", m_tdata, 64'h0);
        checkOutput("async_ready", 64'(s_tready), 64'h0);
        checkOutput("async_count", 64'(pkt_count), 64'h0);
        nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("post_rst_idle", 64'(s_tready), 64'h0);
        nextCycle();
        checkOutput("post_rst_grant", 64'(s_tready), 64'h1);
        checkOutput("post_rst_mvalid", 64'(m_tvalid), 64'h0);
        s_tlast = 2'b01;
        nextCycle();
        s_tvalid = 2'b00;
        s_tlast  = 2'b00;
        #1;
        checkOutput("post_rst_mlast", 64'(m_tlast), 64'h1);
        checkOutput("post_rst_mdata", m_tdata, {8{8'h52}});
        nextCycle();
        checkOutput("post_rst_count", 64'(pkt_count), 64'h1);

        // Four-lane instance: lone ch3 request, then round-robin among ch1/ch2.
        $display("[TB] four-lane instance");
        send4(4'b1000, 3, 8'h31);
        send4(4'b0110, 1, 8'h32);
        send4(4'b0110, 2, 8'h33);
        checkOutput("n4_count", 64'(pkt4_count), 64'h1110);

        // Counter wrap on ch1 of the 4-bit-counter instance.
        for (int i = 0; i < 14; i++) begin
            send4(4'b0010, 1, 8'(8'h40 + i));
        end
        nextCycle();
        checkOutput("n4_count_max", 64'(pkt4_count[7:4]), 64'hF);
        send4(4'b0010, 1, 8'h5F);
        nextCycle();
        checkOutput("n4_count_wrap", 64'(pkt4_count[7:4]), 64'h0);
        checkOutput("n4_count_others", 64'({pkt4_count[15:8], pkt4_count[3:0]}), 64'h110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
